// File: rtl/game_flow_pkg.sv
// Shared types and width helpers for the Bomber Man game flow controller.
package game_flow_pkg;

    // Width of the encoded state exposed on state_o.
    localparam int STATE_W = 4;

    // Top-level game flow states; the enum value is what state_o reports.
    typedef enum logic [STATE_W-1:0] {
        MENU       = 4'd0,
        LOAD_LEVEL = 4'd1,
        PLAY       = 4'd2,
        PAUSE      = 4'd3,
        LIFE_LOST  = 4'd4,
        OVER_TIME  = 4'd5,
        OVER_LIVES = 4'd6,
        WIN        = 4'd7
    } state_t;

    // Bits needed to index n items, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_flow_sm_if.sv
// Signal bundle between the gameplay/video blocks and the game flow controller.
// All inputs are sampled on the rising clock edge; outputs are registered.
// master = the surrounding system driving keys, events and pixels,
// slave  = the game flow controller.
interface game_flow_sm_if
    import game_flow_pkg::*;
#(
    parameter int NUM_MENU_PAGES = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LIVES_INIT     = 3,
    parameter int RGB_W          = 8
);
    localparam int LVL_W = width_of(NUM_LEVELS);
    localparam int LIV_W = width_of(LIVES_INIT + 1);

    // Keyboard levels and gameplay events
    logic                                    enter_key;
    logic                                    pause_key;
    logic                                    timer_ended;
    logic                                    player_died;
    logic                                    level_cleared;

    // Pixel sources
    logic [NUM_MENU_PAGES-1:0]               menu_DR;
    logic [NUM_MENU_PAGES-1:0][RGB_W-1:0]    menu_RGB;
    logic [RGB_W-1:0]                        menu_bg_RGB;
    logic [RGB_W-1:0]                        game_RGB;
    logic                                    pause_DR;
    logic [RGB_W-1:0]                        pause_RGB;
    logic                                    over_time_DR;
    logic [RGB_W-1:0]                        over_time_RGB;
    logic                                    over_lives_DR;
    logic [RGB_W-1:0]                        over_lives_RGB;
    logic                                    win_DR;
    logic [RGB_W-1:0]                        win_RGB;
    logic [RGB_W-1:0]                        over_bg_RGB;

    // Controller outputs
    logic [RGB_W-1:0]                        RGBOut;
    logic                                    game_on;
    logic                                    level_start;
    logic                                    respawn;
    logic [LVL_W-1:0]                        level_idx;
    logic [LIV_W-1:0]                        lives_left;
    logic [STATE_W-1:0]                      state_o;

    modport master (
        output enter_key, pause_key, timer_ended, player_died, level_cleared,
        output menu_DR, menu_RGB, menu_bg_RGB, game_RGB,
        output pause_DR, pause_RGB, over_time_DR, over_time_RGB,
        output over_lives_DR, over_lives_RGB, win_DR, win_RGB, over_bg_RGB,
        input  RGBOut, game_on, level_start, respawn, level_idx, lives_left, state_o
    );

    modport slave (
        input  enter_key, pause_key, timer_ended, player_died, level_cleared,
        input  menu_DR, menu_RGB, menu_bg_RGB, game_RGB,
        input  pause_DR, pause_RGB, over_time_DR, over_time_RGB,
        input  over_lives_DR, over_lives_RGB, win_DR, win_RGB, over_bg_RGB,
        output RGBOut, game_on, level_start, respawn, level_idx, lives_left, state_o
    );

endinterface

// File: rtl/game_flow_sm_key_edge_det.sv
// Rising-edge detectors for keyboard level signals. The history register
// resets to 1 so a key already held when reset releases never fires.
module key_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_key,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_key_q;

    // Remember last cycle's key level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q <= '1;
        end else begin
            r_key_q <= i_key;
        end
    end

    assign o_rise = i_key & ~r_key_q;

endmodule

// File: rtl/game_flow_sm.sv
// Bomber Man game flow controller: menu pages, level loading, play with a
// lives counter, pause, respawn delay and three end screens. Selects the
// registered pixel for the VGA path and reports level/lives status.
module game_flow_sm
    import game_flow_pkg::*;
#(
    parameter int NUM_MENU_PAGES = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LIVES_INIT     = 3,
    parameter int RESPAWN_CYCLES = 50_000_000,
    parameter int RGB_W          = 8
) (
    input  logic           clk,
    input  logic           reset,
    game_flow_sm_if.slave  bus
);

    localparam int PAGE_W = width_of(NUM_MENU_PAGES);
    localparam int LVL_W  = width_of(NUM_LEVELS);
    localparam int LIV_W  = width_of(LIVES_INIT + 1);
    localparam int CNT_W  = width_of(RESPAWN_CYCLES);

    localparam logic [PAGE_W-1:0] LAST_PAGE  = PAGE_W'(NUM_MENU_PAGES - 1);
    localparam logic [LVL_W-1:0]  LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIV_W-1:0]  LIVES_FULL = LIV_W'(LIVES_INIT);
    localparam logic [LIV_W-1:0]  ONE_LIFE   = LIV_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);

    // Key edges
    logic [1:0]        w_keys;
    logic [1:0]        w_rise;
    logic              w_enter_rise;
    logic              w_pause_rise;

    // Registered state and outputs
    state_t            r_state;
    logic [PAGE_W-1:0] r_page;
    logic [LVL_W-1:0]  r_level;
    logic [LIV_W-1:0]  r_lives;
    logic [CNT_W-1:0]  r_cnt;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_game_on;
    logic              r_level_start;
    logic              r_respawn;

    // Next-state values
    state_t            w_state_nxt;
    logic [PAGE_W-1:0] w_page_nxt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [LIV_W-1:0]  w_lives_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Pixel selection
    logic              w_menu_dr;
    logic [RGB_W-1:0]  w_menu_px;
    logic [RGB_W-1:0]  w_rgb_nxt;

    assign w_keys       = {bus.pause_key, bus.enter_key};
    assign w_enter_rise = w_rise[0];
    assign w_pause_rise = w_rise[1];

    key_edge_det #(.W(1)) u_enter_edge (
        .clk    (clk),
        .reset  (reset),
        .i_key  (w_keys[0]),
        .o_rise (w_rise[0])
    );

    key_edge_det #(.W(1)) u_pause_edge (
        .clk    (clk),
        .reset  (reset),
        .i_key  (w_keys[1]),
        .o_rise (w_rise[1])
    );

    // Transition rules; one transition per cycle, events resolved by priority
    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_level_nxt = r_level;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            MENU: begin
                if (w_enter_rise) begin
                    if (r_page < LAST_PAGE) begin
                        w_page_nxt = r_page + PAGE_W'(1);
                    end else begin
                        w_state_nxt = LOAD_LEVEL;
                        w_level_nxt = '0;
                        w_lives_nxt = LIVES_FULL;
                    end
                end
            end
            LOAD_LEVEL: begin
                w_state_nxt = PLAY;
            end
            PLAY: begin
                if (bus.player_died) begin
                    // Lives never drop below zero; the last life ends the run
                    if (r_lives > ONE_LIFE) begin
                        w_lives_nxt = r_lives - ONE_LIFE;
                        w_state_nxt = LIFE_LOST;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_lives_nxt = '0;
                        w_state_nxt = OVER_LIVES;
                    end
                end else if (bus.timer_ended) begin
                    w_state_nxt = OVER_TIME;
                end else if (bus.level_cleared) begin
                    if (r_level >= LAST_LVL) begin
                        w_state_nxt = WIN;
                    end else begin
                        w_level_nxt = r_level + LVL_W'(1);
                        w_state_nxt = LOAD_LEVEL;
                    end
                end else if (w_pause_rise) begin
                    w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (w_pause_rise) begin
                    w_state_nxt = PLAY;
                end
            end
            LIFE_LOST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            OVER_TIME, OVER_LIVES, WIN: begin
                if (w_enter_rise) begin
                    w_state_nxt = MENU;
                    w_page_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = MENU;
                w_page_nxt  = '0;
            end
        endcase
    end

    // Text pixel of the menu page that will be shown next cycle
    always_comb begin
        w_menu_dr = 1'b0;
        w_menu_px = '0;
        for (int i = 0; i < NUM_MENU_PAGES; i++) begin
            if (w_page_nxt == PAGE_W'(i)) begin
                w_menu_dr = bus.menu_DR[i];
                w_menu_px = bus.menu_RGB[i];
            end
        end
    end

    // Pixel mux keyed on the next state so a new screen appears immediately
    always_comb begin
        w_rgb_nxt = bus.game_RGB;
        unique case (w_state_nxt)
            MENU:       w_rgb_nxt = w_menu_dr ? w_menu_px : bus.menu_bg_RGB;
            PAUSE:      w_rgb_nxt = bus.pause_DR ? bus.pause_RGB : bus.game_RGB;
            OVER_TIME:  w_rgb_nxt = bus.over_time_DR ? bus.over_time_RGB : bus.over_bg_RGB;
            OVER_LIVES: w_rgb_nxt = bus.over_lives_DR ? bus.over_lives_RGB : bus.over_bg_RGB;
            WIN:        w_rgb_nxt = bus.win_DR ? bus.win_RGB : bus.over_bg_RGB;
            default:    w_rgb_nxt = bus.game_RGB;
        endcase
    end

    // State register with all outputs registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MENU;
            r_page        <= '0;
            r_level       <= '0;
            r_lives       <= LIVES_FULL;
            r_cnt         <= '0;
            r_rgb         <= '0;
            r_game_on     <= 1'b0;
            r_level_start <= 1'b0;
            r_respawn     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_page        <= w_page_nxt;
            r_level       <= w_level_nxt;
            r_lives       <= w_lives_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rgb         <= w_rgb_nxt;
            r_game_on     <= (w_state_nxt == PLAY);
            r_level_start <= (w_state_nxt == LOAD_LEVEL);
            r_respawn     <= (r_state == LIFE_LOST) && (w_state_nxt == PLAY);
        end
    end

    assign bus.RGBOut      = r_rgb;
    assign bus.game_on     = r_game_on;
    assign bus.level_start = r_level_start;
    assign bus.respawn     = r_respawn;
    assign bus.level_idx   = r_level;
    assign bus.lives_left  = r_lives;
    assign bus.state_o     = r_state;

endmodule
